// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg
//   Shared definitions for the ID-stage branch resolution unit: the branch
//   opcode, the supported funct3 encodings, the resolve FSM state type and the
//   instruction size used to form the fall-through PC.
package branch_resolve_unit_pkg;

  localparam logic [6:0] BRANCH_OP  = 7'b1100011;
  localparam logic [2:0] FUNCT3_BEQ = 3'b000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;
  localparam int         INST_BYTES = 4;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_pred_reg.sv
// bru_pred_reg
//   IF/ID prediction pipeline register. Carries the IF-stage predictor output
//   alongside the instruction it belongs to, so ID can judge the prediction.
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   stall            hold all contents
//   flush            drop the incoming IF slot (valid loads 0)
//   if_valid         IF holds a real instruction
//   if_pred_taken    predictor taken for the IF PC
//   if_pred_target   predictor target for the IF PC
//   vld_p1           registered valid
//   taken_p1         registered predicted direction
//   target_p1        registered predicted target
module bru_pred_reg #(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            if_valid,
  input  logic            if_pred_taken,
  input  logic [PC_W-1:0] if_pred_target,
  output logic            vld_p1,
  output logic            taken_p1,
  output logic [PC_W-1:0] target_p1
);

  // IF -> ID boundary: valid is reset, payload is not (it is qualified by vld_p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= if_valid & ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      taken_p1  <= if_pred_taken;
      target_p1 <= if_pred_target;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   ID-stage branch resolution. Compares the prediction latched alongside the
//   ID instruction against the actual BEQ/BNE outcome, emits one predictor
//   update per branch and, on a misprediction (or a predicted-taken
//   non-branch), a one-cycle flush with the corrected fetch PC.
// Optional feature: define BRU_STATS_EN to add saturating branch and
//   mispredict counters (stat_branches, stat_mispredicts).
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   if_valid             IF holds a real instruction
//   if_pred_taken        predictor taken output for the IF PC
//   if_pred_target       predictor target for the IF PC
//   stall                hazard stall, IF/ID frozen
//   id_inst              instruction in ID
//   id_pc                PC of the ID instruction
//   id_imm               sign-extended branch byte offset
//   id_rs_equal          rs1 == rs2 from the ID comparator
//   upd_valid            predictor update strobe
//   upd_taken            actual branch outcome
//   upd_target           actual taken target id_pc + id_imm
//   flush                kill IF/ID contents at the next edge
//   redirect_pc          corrected fetch PC, valid when flush = 1
//   stat_branches        (BRU_STATS_EN) resolved branch count
//   stat_mispredicts     (BRU_STATS_EN) flush count
module branch_resolve_unit #(
  parameter int         PC_W      = 64,
  parameter logic [6:0] BRANCH_OP = branch_resolve_unit_pkg::BRANCH_OP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic            if_pred_taken,
  input  logic [PC_W-1:0] if_pred_target,
  input  logic            stall,
  input  logic [31:0]     id_inst,
  input  logic [PC_W-1:0] id_pc,
  input  logic [PC_W-1:0] id_imm,
  input  logic            id_rs_equal,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic [PC_W-1:0] upd_target,
  output logic            flush,
`ifdef BRU_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic [PC_W-1:0] redirect_pc
);

  import branch_resolve_unit_pkg::*;

  logic            vld_p1;
  logic            taken_p1;
  logic [PC_W-1:0] target_p1;

  bru_pred_reg #(.PC_W(PC_W)) u_pred_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .vld_p1         (vld_p1),
    .taken_p1       (taken_p1),
    .target_p1      (target_p1)
  );

  bru_state_e      state;
  logic [2:0]      funct3;
  logic            is_br;
  logic            actual;
  logic            active;
  logic            mispred;
  logic            alias_hit;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] seq_pc;

  always_comb begin
    funct3    = id_inst[14:12];
    is_br     = vld_p1 & (id_inst[6:0] == BRANCH_OP) &
                ((funct3 == FUNCT3_BEQ) | (funct3 == FUNCT3_BNE));
    actual    = (funct3 == FUNCT3_BEQ) ? id_rs_equal : ~id_rs_equal;
    br_target = id_pc + id_imm;
    seq_pc    = id_pc + PC_W'(INST_BYTES);
    active    = (state == RUN) & ~stall;
    // A correctly predicted direction can still be wrong if the predictor
    // supplied a stale target for a taken branch.
    mispred   = is_br & ((actual != taken_p1) |
                         (actual & taken_p1 & (target_p1 != br_target)));
    // Predictor aliased onto a non-branch: fetch went off-path.
    alias_hit = vld_p1 & ~is_br & taken_p1;

    upd_valid   = active & is_br;
    upd_taken   = is_br & actual;
    upd_target  = is_br ? br_target : '0;
    flush       = active & (mispred | alias_hit);
    redirect_pc = '0;
    if (flush) begin
      redirect_pc = (is_br & actual) ? br_target : seq_pc;
    end
  end

  // ID resolve FSM: SQUASH covers the bubble left in ID after a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (!stall) begin
      case (state)
        RUN:     if (flush) state <= SQUASH;
        SQUASH:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (flush && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//   Directed bench for branch_resolve_unit with hand-computed expectations.
//   Build with BRU_STATS_EN defined to also check the statistics counters.
module tb_branch_resolve_unit;

  localparam int PC_W = 64;
  localparam logic [31:0] I_BEQ = 32'h0000_0063;
  localparam logic [31:0] I_BNE = 32'h0000_1063;
  localparam logic [31:0] I_BLT = 32'h0000_4063;
  localparam logic [31:0] I_ADD = 32'h0000_0033;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic            if_pred_taken;
  logic [PC_W-1:0] if_pred_target;
  logic            stall;
  logic [31:0]     id_inst;
  logic [PC_W-1:0] id_pc;
  logic [PC_W-1:0] id_imm;
  logic            id_rs_equal;
  logic            upd_valid;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(PC_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .stall          (stall),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .id_rs_equal    (id_rs_equal),
    .upd_valid      (upd_valid),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .flush          (flush),
`ifdef BRU_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .redirect_pc    (redirect_pc)
  );

  // Present a prediction in IF, clock it into the IF/ID register, then
  // stop presenting valid instructions so later edges load bubbles.
  task automatic load_pred(input logic taken, input logic [PC_W-1:0] target);
    if_valid       = 1'b1;
    if_pred_taken  = taken;
    if_pred_target = target;
    @(posedge clk);
    #1;
    if_valid       = 1'b0;
    if_pred_taken  = 1'b0;
    if_pred_target = '0;
  endtask

  task automatic set_id(input logic [31:0] inst, input logic [PC_W-1:0] pc,
                        input logic [PC_W-1:0] imm, input logic eq);
    id_inst     = inst;
    id_pc       = pc;
    id_imm      = imm;
    id_rs_equal = eq;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    if_valid = 1'b1; if_pred_taken = 1'b1; if_pred_target = 64'h140;
    id_inst = I_BEQ; id_pc = 64'h100; id_imm = 64'h40; id_rs_equal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; if_valid = 1'b0; if_pred_taken = 1'b0; if_pred_target = '0;
    #1;
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b000) begin
      $display("FAIL reset_strobes got %b want 000", {upd_valid, upd_taken, flush}); n_fail++;
    end
    n_checks++;
    if (upd_target !== 64'h0 || redirect_pc !== 64'h0) begin
      $display("FAIL reset_pcs got %h/%h want 0/0", upd_target, redirect_pc); n_fail++;
    end
`ifdef BRU_STATS_EN
    n_checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispredicts); n_fail++;
    end
`endif
  endtask

  task automatic test_correct_taken();
    load_pred(1'b1, 64'h140);
    set_id(I_BEQ, 64'h100, 64'h40, 1'b1);
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b110) begin
      $display("FAIL beq_hit_strobes got %b want 110", {upd_valid, upd_taken, flush}); n_fail++;
    end
    n_checks++;
    if (upd_target !== 64'h140) begin
      $display("FAIL beq_hit_target got %h want 140", upd_target); n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if ({upd_valid, flush} !== 2'b00) begin
      $display("FAIL beq_hit_after got %b want 00", {upd_valid, flush}); n_fail++;
    end
  endtask

  task automatic test_mispredict_not_taken();
    load_pred(1'b0, 64'h0);
    set_id(I_BEQ, 64'h100, 64'h40, 1'b1);
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b111) begin
      $display("FAIL beq_nt_strobes got %b want 111", {upd_valid, upd_taken, flush}); n_fail++;
    end
    n_checks++;
    if (redirect_pc !== 64'h140) begin
      $display("FAIL beq_nt_redirect got %h want 140", redirect_pc); n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if ({upd_valid, flush} !== 2'b00) begin
      $display("FAIL beq_nt_squash got %b want 00", {upd_valid, flush}); n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bne_mispredict();
    load_pred(1'b1, 64'h180);
    set_id(I_BNE, 64'h200, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b101) begin
      $display("FAIL bne_strobes got %b want 101", {upd_valid, upd_taken, flush}); n_fail++;
    end
    n_checks++;
    if (redirect_pc !== 64'h204 || upd_target !== 64'h180) begin
      $display("FAIL bne_pcs got %h/%h want 204/180", redirect_pc, upd_target); n_fail++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_target_mismatch();
    load_pred(1'b1, 64'h180);
    set_id(I_BEQ, 64'h100, 64'h40, 1'b1);
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b111 || redirect_pc !== 64'h140) begin
      $display("FAIL tgt_mismatch got %b/%h want 111/140",
               {upd_valid, upd_taken, flush}, redirect_pc); n_fail++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int seen;
    load_pred(1'b0, 64'h0);
    stall = 1'b1;
    set_id(I_BEQ, 64'h100, 64'h40, 1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (upd_valid === 1'b1) seen++;
      if (i < 2) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (seen != 0) begin
      $display("FAIL stall_hold got %0d updates want 0", seen); n_fail++;
    end
    stall = 1'b0; #1;
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b100) begin
      $display("FAIL stall_release got %b want 100", {upd_valid, upd_taken, flush}); n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (upd_valid !== 1'b0) begin
      $display("FAIL stall_once got %b want 0", upd_valid); n_fail++;
    end
    // stalled mispredict must not flush until it is allowed through
    load_pred(1'b0, 64'h0);
    stall = 1'b1;
    set_id(I_BEQ, 64'h100, 64'h40, 1'b1);
    n_checks++;
    if ({upd_valid, flush} !== 2'b00) begin
      $display("FAIL stall_flush got %b want 00", {upd_valid, flush}); n_fail++;
    end
    stall = 1'b0; #1;
    n_checks++;
    if ({upd_valid, flush} !== 2'b11 || redirect_pc !== 64'h140) begin
      $display("FAIL stall_flush_rel got %b/%h want 11/140", {upd_valid, flush}, redirect_pc); n_fail++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_alias();
`ifdef BRU_STATS_EN
    logic [31:0] b0, m0;
`endif
    load_pred(1'b1, 64'h500);
    set_id(I_ADD, 64'h300, 64'h0, 1'b0);
`ifdef BRU_STATS_EN
    b0 = stat_branches; m0 = stat_mispredicts;
`endif
    n_checks++;
    if ({upd_valid, flush} !== 2'b01 || redirect_pc !== 64'h304) begin
      $display("FAIL alias_add got %b/%h want 01/304", {upd_valid, flush}, redirect_pc); n_fail++;
    end
    @(posedge clk); #1;
`ifdef BRU_STATS_EN
    n_checks++;
    if (stat_mispredicts !== m0 + 32'd1 || stat_branches !== b0) begin
      $display("FAIL alias_stats got %0d/%0d want %0d/%0d",
               stat_branches, stat_mispredicts, b0, m0 + 32'd1); n_fail++;
    end
`endif
    @(posedge clk); #1;
    // unsupported funct3 behaves as a non-branch
    load_pred(1'b1, 64'h500);
    set_id(I_BLT, 64'h400, 64'h40, 1'b1);
    n_checks++;
    if ({upd_valid, flush} !== 2'b01 || redirect_pc !== 64'h404 || upd_target !== 64'h0) begin
      $display("FAIL alias_blt got %b/%h/%h want 01/404/0",
               {upd_valid, flush}, redirect_pc, upd_target); n_fail++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    // non-branch predicted not taken: nothing happens
    load_pred(1'b0, 64'h0);
    set_id(I_ADD, 64'h300, 64'h0, 1'b0);
    n_checks++;
    if ({upd_valid, flush} !== 2'b00 || redirect_pc !== 64'h0) begin
      $display("FAIL plain_add got %b/%h want 00/0", {upd_valid, flush}, redirect_pc); n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    load_pred(1'b0, 64'h0);
    set_id(I_BEQ, 64'h100, 64'h40, 1'b1);
    rst = 1'b1; if_valid = 1'b1; if_pred_taken = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b000 || redirect_pc !== 64'h0) begin
      $display("FAIL reset_mid got %b/%h want 000/0",
               {upd_valid, upd_taken, flush}, redirect_pc); n_fail++;
    end
    rst = 1'b0; if_valid = 1'b0; if_pred_taken = 1'b0;
    // back in RUN: a following correct branch updates normally
    load_pred(1'b0, 64'h0);
    set_id(I_BEQ, 64'h100, 64'h40, 1'b0);
    n_checks++;
    if ({upd_valid, upd_taken, flush} !== 3'b100) begin
      $display("FAIL reset_mid_run got %b want 100", {upd_valid, upd_taken, flush}); n_fail++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_mispredict_not_taken();
    test_bne_mispredict();
    test_target_mismatch();
    test_stall();
    test_alias();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no end want end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch resolution for the five-stage 64-bit core; the write-side counterpart of the IF-stage branch predictor. Latches the IF-stage prediction into an IF/ID prediction register and resolves the branch in ID against the actual outcome. Emits the single predictor-update strobe and, on misprediction, a one-cycle flush plus redirect PC to the fetch mux. Branch opcode 7'b1100011; BEQ (funct3 000) and BNE (funct3 001) supported.

## Interface
- Parameters:
- PC_W, 64, PC/target width
- BRANCH_OP, 7'b1100011, branch opcode
- Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  IF holds a real instruction
- if_pred_taken  in  1  predictor taken output for IF PC
- if_pred_target  in  PC_W  predictor target for IF PC
- stall  in  1  hazard stall; IF/ID frozen
- id_inst  in  32  instruction in ID
- id_pc  in  PC_W  PC of ID instruction
- id_imm  in  PC_W  sign-extended branch byte offset
- id_rs_equal  in  1  rs1 == rs2 from ID comparator
- upd_valid  out  1  predictor update strobe
- upd_taken  out  1  actual outcome (predictor "branched")
- upd_target  out  PC_W  actual taken target id_pc+id_imm
- flush  out  1  kill IF/ID contents next edge
- redirect_pc  out  PC_W  corrected fetch PC, valid when flush=1

## Operation
- Prediction register {p_valid, p_taken, p_target}: on edge with stall=0 loads {if_valid & ~flush, if_pred_taken, if_pred_target}; stall=1 holds; flush=1 loads p_valid=0.
- is_br = p_valid & (id_inst[6:0]==BRANCH_OP) & funct3∈{000,001}; actual = funct3==000 ? id_rs_equal : ~id_rs_equal.
- FSM states RUN, SQUASH.
- RUN, stall=0, is_br: upd_valid=1. Mispredict when: actual≠p_taken, or actual=p_taken=1 and p_target≠id_pc+id_imm. Mispredict -> flush=1, redirect_pc = actual ? id_pc+id_imm : id_pc+4; next state SQUASH.
- RUN, stall=0, p_valid, non-branch, p_taken=1 (alias hit): flush=1, redirect_pc=id_pc+4, upd_valid=0; go SQUASH.
- SQUASH: ID slot is a bubble; upd_valid=0, flush=0. Leaves to RUN on first cycle with stall=0; holds while stall=1.
- stall=1 in any state: upd_valid=0, flush=0, state holds. Guarantees exactly one update and at most one flush per branch.
- Address arithmetic modulo 2^PC_W; wrap ignored.
- rst mid-operation: state RUN, p_valid=0, all strobes low next cycle; pending resolution discarded.

## Timing
- upd_*, flush, redirect_pc combinational from prediction register, FSM state, ID inputs; same cycle the branch is in ID with stall=0.
- Predictor captures update on same edge; misprediction penalty one bubble cycle.
- Reset values: upd_valid=0, upd_taken=0, upd_target=0, flush=0, redirect_pc=0 (all outputs forced 0 while p_valid=0).
- upd_target driven id_pc+id_imm whenever is_br, independent of outcome.

## Configuration
- BRU_STATS_EN defined: adds outputs stat_branches (32) and stat_mispredicts (32); increment on upd_valid and on flush respectively; saturate at 2^32-1; cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: BRANCH_OP, FUNCT3_BEQ/FUNCT3_BNE, FSM state enum {RUN, SQUASH}, INST_BYTES=4.
- One sub-module natural: bru_pred_reg (prediction pipeline register with stall/flush); FSM and compare logic in top.

## Test plan
- Reset: rst=1 two cycles, release -> all outputs 0, state RUN, no update on first ID cycle.
- BEQ at id_pc=0x100, imm=0x40, rs_equal=1, predicted taken target 0x140 -> upd_valid=1, upd_taken=1, upd_target=0x140, flush=0.
- Same BEQ, predicted not taken -> flush=1, redirect_pc=0x140; next cycle upd_valid=0, flush=0; RUN after.
- BNE at 0x200, rs_equal=1, predicted taken target 0x180 -> upd_taken=0, flush=1, redirect_pc=0x204.
- Stalled branch: stall=1 three cycles then 0 -> upd_valid exactly once, on the unstalled cycle.
- ADD at 0x300 with p_taken=1 -> flush=1, redirect_pc=0x304, upd_valid=0; with BRU_STATS_EN stat_mispredicts +1, stat_branches unchanged.
